// File: rtl/uart_result_tx.sv
// uart_result_tx: serializes one result word as BYTES back-to-back 8N1 UART frames, least-significant byte first
module uart_result_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BYTES        = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [8*BYTES-1:0] data_i,
  input  logic               valid_i,
  output logic               ready_o,
  output logic               tx_o,
  output logic               busy_o,
  output logic               done_o
);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int YW = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BW-1:0] B_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] B_PRE  = BW'(CLKS_PER_BIT - 2);
  localparam logic [YW-1:0] Y_LAST = YW'(BYTES - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t             r_state;
  logic [BW-1:0]      r_baud;
  logic [2:0]         r_bit;
  logic [YW-1:0]      r_byte;
  logic [8*BYTES-1:0] r_sh;
  logic               r_tx;
  logic               r_done;
  logic               w_bit_end;
  logic [BW-1:0]      w_baud_nx;
  assign w_bit_end = r_baud == B_LAST;
  assign w_baud_nx = w_bit_end ? '0 : r_baud + BW'(1);
  assign ready_o   = r_state == IDLE;
  assign busy_o    = !ready_o;
  assign tx_o      = r_tx;
  assign done_o    = r_done;
  // Frame sequencer; the shift register drops one data bit per bit period, and done is
  // raised one cycle early so it is high exactly during the final stop-bit cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_byte  <= '0;
      r_sh    <= '0;
      r_tx    <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == STOP) && (r_byte == Y_LAST) && (r_baud == B_PRE);
      case (r_state)
        IDLE: if (valid_i) begin
          r_sh    <= data_i;
          r_tx    <= 1'b0;
          r_baud  <= '0;
          r_bit   <= '0;
          r_byte  <= '0;
          r_state <= START;
        end
        START: begin
          r_baud <= w_baud_nx;
          if (w_bit_end) begin
            r_tx    <= r_sh[0];
            r_sh    <= r_sh >> 1;
            r_bit   <= '0;
            r_state <= DATA;
          end
        end
        DATA: begin
          r_baud <= w_baud_nx;
          if (w_bit_end) begin
            if (r_bit == 3'd7) begin
              r_tx    <= 1'b1;
              r_state <= STOP;
            end else begin
              r_tx  <= r_sh[0];
              r_sh  <= r_sh >> 1;
              r_bit <= r_bit + 3'd1;
            end
          end
        end
        STOP: begin
          r_baud <= w_baud_nx;
          if (w_bit_end) begin
            if (r_byte == Y_LAST) begin
              r_byte  <= '0;
              r_tx    <= 1'b1;
              r_state <= IDLE;
            end else begin
              r_byte  <= r_byte + YW'(1);
              r_tx    <= 1'b0;
              r_state <= START;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_result_tx.sv
// tb_uart_result_tx: directed vectors checking waveform, framing, handshake and reset behaviour
module tb_uart_result_tx;
  localparam int CPB = 4;
  localparam int NB  = 4;
  localparam int FR  = 10 * CPB;
  localparam int WT  = NB * FR;
  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [31:0] data;
  logic        ready, tx, busy, done;
  int          errors = 0;
  int          checks = 0;
  logic [7:0]  rx_q[$];
  typedef struct {
    logic [31:0] word;
    bit          toggle;
  } vec_t;
  vec_t vt[5];

  uart_result_tx #(.CLKS_PER_BIT(CPB), .BYTES(NB)) dut (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid),
    .ready_o(ready), .tx_o(tx), .busy_o(busy), .done_o(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_bit(input logic [31:0] w, input int k);
    int f, p;
    f = (k - 1) / FR;
    p = ((k - 1) % FR) / CPB;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return w[8*f + p - 1];
  endfunction

  task automatic idle_chk(input string name);
    @(negedge clk);
    chk({name, "_tx"}, 32'(tx), 32'd1);
    chk({name, "_ready"}, 32'(ready), 32'd1);
    chk({name, "_busy"}, 32'(busy), 32'd0);
    chk({name, "_done"}, 32'(done), 32'd0);
  endtask

  // Entered at a negedge with valid=1 and data=w already driven while the DUT is idle.
  task automatic run_word(input logic [31:0] w, input bit toggle, input logic nv, input logic [31:0] nd);
    logic [7:0] b;
    int p;
    b = 8'h00;
    @(posedge clk);
    for (int k = 1; k <= WT; k++) begin
      @(negedge clk);
      chk("tx", 32'(tx), 32'(exp_bit(w, k)));
      chk("busy", 32'(busy), 32'd1);
      chk("done", 32'(done), 32'(k == WT));
      p = ((k - 1) % FR) / CPB;
      if ((k - 1) % CPB == 1 && p >= 1 && p <= 8) b[p-1] = tx;
      if (k % FR == 0) begin
        rx_q.push_back(b);
        chk("rx_byte", 32'(b), 32'(w[8*((k-1)/FR) +: 8]));
      end
      if (toggle) begin
        valid = 1'($urandom_range(0, 1));
        data  = $urandom;
      end else valid = 1'b0;
      if (k == WT) begin
        valid = nv;
        data  = nd;
      end
    end
    @(negedge clk);
    chk("ready_after", 32'(ready), 32'd1);
    chk("tx_gap", 32'(tx), 32'd1);
    chk("done_clear", 32'(done), 32'd0);
  endtask

  initial begin
    logic [7:0] exp_q[$];
    rst = 1'b1; valid = 1'b0; data = '0;
    vt[0] = '{32'h12345678, 1'b0};
    vt[1] = '{32'h000000FF, 1'b0};
    vt[2] = '{32'h00000000, 1'b0};
    vt[3] = '{32'hFFFFFFFF, 1'b0};
    vt[4] = '{32'h3C5A9617, 1'b1};
    for (int i = 0; i < 5; i++) idle_chk("reset");
    rst = 1'b0;
    for (int i = 0; i < 100; i++) idle_chk("idle");
    for (int i = 0; i < 5; i++) begin
      chk("ready_pre", 32'(ready), 32'd1);
      valid = 1'b1; data = vt[i].word;
      rx_q.delete();
      run_word(vt[i].word, vt[i].toggle, 1'b0, 32'h0);
      chk("rx_count", 32'(rx_q.size()), 32'(NB));
      for (int j = 0; j < 3; j++) idle_chk("post");
    end
    rx_q.delete();
    valid = 1'b1; data = 32'hA5A5A5A5;
    run_word(32'hA5A5A5A5, 1'b0, 1'b1, 32'h0000C3C3);
    run_word(32'h0000C3C3, 1'b0, 1'b0, 32'h0);
    exp_q = '{8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'hC3, 8'hC3, 8'h00, 8'h00};
    chk("b2b_count", 32'(rx_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < rx_q.size(); i++) chk("b2b_byte", 32'(rx_q[i]), 32'(exp_q[i]));
    idle_chk("b2b_end");
    valid = 1'b1; data = 32'h12345678;
    @(posedge clk);
    for (int k = 1; k <= 58; k++) begin
      @(negedge clk);
      valid = 1'b0;
      if (k == 58) chk("pre_rst_tx", 32'(tx), 32'(exp_bit(32'h12345678, k)));
    end
    rst = 1'b1; valid = 1'b1; data = 32'hFFFFFFFF;
    @(negedge clk);
    chk("rst_mid_tx", 32'(tx), 32'd1);
    chk("rst_mid_ready", 32'(ready), 32'd1);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    rst = 1'b0; valid = 1'b0;
    for (int i = 0; i < 200; i++) idle_chk("after_rst");
    rx_q.delete();
    valid = 1'b1; data = 32'hDEADBEEF;
    run_word(32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    exp_q = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    chk("dead_count", 32'(rx_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < rx_q.size(); i++) chk("dead_byte", 32'(rx_q[i]), 32'(exp_q[i]));
    idle_chk("final");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_result_tx.md
Name: uart_result_tx

Overview:
- Transmit side of the UART ALU link.
- Accepts one fixed-width result word from the ALU core over a valid/ready handshake.
- Serializes the word onto the board TX pin as BYTES consecutive 8N1 UART frames, least-significant byte first.
- This is the counterpart of the RX packet path. Its frames are what the simulation runner and the host decode on TX.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit. 50 MHz / 115200 baud. Must be >= 2.
- BYTES, 4, number of bytes per result word. Must be >= 1.

Ports:
- clk_i  input  1  core clock.
- rst_i  input  1  synchronous active-high reset.
- data_i  input  8*BYTES  result word; byte 0 = data_i[7:0].
- valid_i  input  1  data_i valid.
- ready_o  output  1  block can accept a word.
- tx_o  output  1  UART serial line, idle high.
- busy_o  output  1  a word is being transmitted.
- done_o  output  1  one-cycle pulse when the last stop bit of a word completes.

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset values: state IDLE, tx_o=1, ready_o=1, busy_o=0, done_o=0, all counters 0. While rst_i=1, valid_i is ignored.
- tx_o is driven directly from a flop, with no combinational path from inputs.
- ready_o = (state==IDLE). busy_o = !ready_o.
- Accept: a word is accepted on a rising clk_i edge when valid_i && ready_o. data_i is latched into a shift register at that edge. After acceptance, data_i and valid_i are don't-care.
- State machine:
  - IDLE -> START on accept.
  - START: tx_o=0 for CLKS_PER_BIT cycles -> DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles -> STOP.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. Then -> START if more bytes remain, else -> IDLE.
- Timing:
  - The start bit appears on tx_o in the cycle immediately after the accept edge.
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - No idle gap between the stop bit of byte k and the start bit of byte k+1.
  - Total busy time per word = BYTES*10*CLKS_PER_BIT cycles.
- Completion:
  - done_o pulses high for one cycle, in the final cycle of the last stop bit.
  - ready_o returns to 1 on the next cycle.
  - A new word presented with valid_i held high is accepted on that cycle, giving back-to-back words with a 1-cycle idle-high gap.
- Counters:
  - The baud counter counts 0..CLKS_PER_BIT-1 and wraps.
  - The bit index runs 0..7 and the byte index 0..BYTES-1. Neither may overflow or alias for any legal parameter.
  - Counter widths are $clog2 of their range, minimum 1.
- Reset mid-frame: on the edge where rst_i=1, all state is abandoned. On the following cycle tx_o=1, ready_o=1, and done_o is not pulsed. The partially sent frame is truncated; the receiver sees a framing error, which is acceptable.
- valid_i while busy: ignored. No queuing. The upstream holds valid_i until ready_o.

Test Plan:
- Reset idle: assert rst_i for 5 cycles, then hold for 100 cycles with valid_i=0 -> tx_o=1, ready_o=1, busy_o=0, done_o=0 throughout.
- Single word (CLKS_PER_BIT=4, BYTES=4): data_i=32'h12345678 for one accepted cycle.
  - Required byte order: 0x78, 0x56, 0x34, 0x12.
  - Bits of the first frame: 0, 0,0,0,1,1,1,1,0, 1, each held 4 cycles.
  - done_o pulses exactly at cycle 160 after acceptance; ready_o=1 at cycle 161.
- Bit timing: sample tx_o every cycle on data_i=32'h000000FF.
  - Every level run is a multiple of 4 cycles.
  - The start-bit run begins the cycle after acceptance.
  - No gap between frames.
- Back-to-back: hold valid_i=1 with 32'hA5A5A5A5, then 32'h0000C3C3 -> second accept exactly one cycle after done_o. A bench UART decoder recovers 8 bytes, A5 A5 A5 A5 C3 C3 00 00.
- Valid while busy: toggle valid_i with random data during transmission -> transmitted bytes are unchanged and no extra word is accepted.
- Reset mid-frame: assert rst_i during DATA bit 3 of byte 1 -> next cycle tx_o=1, ready_o=1, done_o never pulses. A subsequent 32'hDEADBEEF is sent correctly as EF BE AD DE.
